// File: rtl/weight_buf_if.sv
// Weight buffer port bundle: write port from the weight bus unit,
// random-access read port to the MAC array, and sticky error flags.
interface weight_buf_if #(
    parameter int DW = 32
);
    logic [31:0]   weight_waddr;
    logic [DW-1:0] weight_wdata;
    logic          weight_wen;
    logic          wr_bank_free;
    logic          fill_done;
    logic          buf_ready;
    logic [7:0]    rd_och;
    logic          rd_en;
    logic          rd_k1;
    logic [3:0]    rd_pos;
    logic [3:0]    rd_word;
    logic [DW-1:0] rd_data;
    logic          rd_vld;
    logic          mac_release;
    logic          err_clr;
    logic          err_ovf;
    logic          err_addr;
    logic          err_rd;

    modport master (
        output weight_waddr, weight_wdata, weight_wen,
        output rd_en, rd_k1, rd_pos, rd_word,
        output mac_release, err_clr,
        input  wr_bank_free, fill_done, buf_ready, rd_och,
        input  rd_data, rd_vld, err_ovf, err_addr, err_rd
    );

    modport slave (
        input  weight_waddr, weight_wdata, weight_wen,
        input  rd_en, rd_k1, rd_pos, rd_word,
        input  mac_release, err_clr,
        output wr_bank_free, fill_done, buf_ready, rd_och,
        output rd_data, rd_vld, err_ovf, err_addr, err_rd
    );
endinterface

// File: rtl/weight_buf.sv
// Ping-pong weight buffer: one bank fills from the weight bus while
// the MAC array reads the other, one output channel per bank.
module weight_buf #(
    parameter int DW       = 32,
    parameter int K3_WORDS = 144,
    parameter int K1_WORDS = 16
) (
    input logic         clk,
    input logic         rst_n,
    weight_buf_if.slave bus
);
    localparam int BW = K3_WORDS + K1_WORDS;

    logic [DW-1:0] mem [2][BW];

    logic       wr_bank;
    logic       rd_bank;
    logic [1:0] full;
    logic [1:0] full_nxt;
    logic [7:0] wcnt;
    logic [7:0] och_tag [2];
    logic       alive;

    logic          fill_done;
    logic [DW-1:0] rd_data;
    logic          rd_vld;
    logic          err_ovf;
    logic          err_addr;
    logic          err_rd;

    logic       w_k1;
    logic [5:0] w_pos;
    logic       w_bad;
    logic       w_full;
    logic       w_acc;
    logic       w_last;
    logic [7:0] w_idx;
    logic       r_bad;
    logic       r_ok;
    logic [7:0] r_idx;
    logic       rel;
    logic       unused;

    assign w_k1   = bus.weight_waddr[31];
    assign w_pos  = bus.weight_waddr[11:6];
    assign w_bad  = !w_k1 && (w_pos > 6'd8);
    assign w_full = full[wr_bank];
    assign w_acc  = bus.weight_wen && !w_full && !w_bad;
    assign w_last = w_acc && (wcnt == 8'(BW - 1));
    assign w_idx  = w_k1
                  ? 8'(K3_WORDS) + {4'b0, bus.weight_waddr[3:0]}
                  : {w_pos[3:0], bus.weight_waddr[3:0]};

    // Position is a don't-care on 1x1 reads, so only 3x3 reads can be bad.
    assign r_bad = !bus.rd_k1 && (bus.rd_pos > 4'd8);
    assign r_ok  = bus.rd_en && full[rd_bank] && !r_bad;
    assign r_idx = bus.rd_k1
                 ? 8'(K3_WORDS) + {4'b0, bus.rd_word}
                 : {bus.rd_pos, bus.rd_word};

    assign rel = bus.mac_release && full[rd_bank];

    assign unused = ^{bus.weight_waddr[22:12], bus.weight_waddr[5:4]};

    always_comb begin
        full_nxt = full;
        if (rel)
            full_nxt[rd_bank] = 1'b0;
        if (w_last)
            full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_acc)
            mem[wr_bank][w_idx] <= bus.weight_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            full       <= 2'b00;
            wcnt       <= 8'd0;
            och_tag[0] <= 8'd0;
            och_tag[1] <= 8'd0;
            alive      <= 1'b0;
            fill_done  <= 1'b0;
            rd_data    <= '0;
            rd_vld     <= 1'b0;
            err_ovf    <= 1'b0;
            err_addr   <= 1'b0;
            err_rd     <= 1'b0;
        end else begin
            alive     <= 1'b1;
            full      <= full_nxt;
            fill_done <= w_last;
            rd_vld    <= r_ok;
            if (w_acc)
                wcnt <= w_last ? 8'd0 : wcnt + 8'd1;
            if (w_acc && (wcnt == 8'd0))
                och_tag[wr_bank] <= bus.weight_waddr[30:23];
            if (w_last)
                wr_bank <= !wr_bank;
            if (rel)
                rd_bank <= !rd_bank;
            if (r_ok)
                rd_data <= mem[rd_bank][r_idx];
            // A new error wins over a same-cycle clear.
            err_ovf  <= (err_ovf && !bus.err_clr)
                     || (bus.weight_wen && w_full);
            err_addr <= (err_addr && !bus.err_clr)
                     || (bus.weight_wen && w_bad)
                     || (bus.rd_en && r_bad);
            err_rd   <= (err_rd && !bus.err_clr)
                     || (bus.rd_en && !full[rd_bank]);
        end
    end

    assign bus.wr_bank_free = alive && !full[wr_bank];
    assign bus.buf_ready    = full[rd_bank];
    assign bus.rd_och       = och_tag[rd_bank];
    assign bus.fill_done    = fill_done;
    assign bus.rd_data      = rd_data;
    assign bus.rd_vld       = rd_vld;
    assign bus.err_ovf      = err_ovf;
    assign bus.err_addr     = err_addr;
    assign bus.err_rd       = err_rd;
endmodule

// File: doc/weight_buf.md
Name: weight_buf

Overview:
- Ping-pong weight buffer directly downstream of the weight bus interface unit.
- Captures the 160-word (144 3x3 + 16 1x1) weight stream for one output channel from the weight_waddr/weight_wdata/weight_wen write port.
- Serves the captured words to the MAC array through a 1-cycle-latency random-access read port.
- Two banks let the MAC consume channel N while channel N+1 is being fetched.

Parameters:
- DW, 32, weight word width (4 packed int8 weights).
- K3_WORDS, 144, 3x3 words per output channel (9 positions x 16 words).
- K1_WORDS, 16, 1x1 words per output channel.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- weight_waddr  in  32  write address: [31]=0 3x3 / 1 1x1; [30:23] output-channel tag; [11:6] kernel position 0..8; [5:0] input-channel word 0..15.
- weight_wdata  in  DW  write data.
- weight_wen  in  1  write strobe, one word per cycle.
- wr_bank_free  out  1  current write bank is empty; controller issues weight_start only when high.
- fill_done  out  1  one-cycle pulse when a bank completes 160 writes.
- buf_ready  out  1  read bank holds a complete channel.
- rd_och  out  8  channel tag of the read bank.
- rd_en  in  1  read request.
- rd_k1  in  1  0 selects 3x3 region, 1 selects 1x1 region.
- rd_pos  in  4  kernel position 0..8; ignored when rd_k1=1.
- rd_word  in  4  input-channel word 0..15.
- rd_data  out  DW  read data.
- rd_vld  out  1  rd_data valid.
- mac_release  in  1  one-cycle pulse: MAC finished with the read bank.
- err_clr  in  1  clears the sticky error flags.
- err_ovf  out  1  sticky: write arrived while the write bank was full.
- err_addr  out  1  sticky: 3x3 write with position > 8, or read with position > 8.
- err_rd  out  1  sticky: rd_en while buf_ready=0.

Behaviour:
- Storage: 2 banks x 160 words. Index = pos*16+word for 3x3; 144+word for 1x1. The position field is ignored on 1x1 accesses. Memory contents are not reset.
- State registers: wr_bank, rd_bank (1 bit each), full[1:0], wcnt (8 bits), och_tag[1:0] (8 bits each).
- Reset (async): wr_bank=rd_bank=0, full=0, wcnt=0, tags=0, and every output 0 (rd_data=0). After release of reset, wr_bank_free=1. A reset mid-fill discards the partial bank.
- Accepted write: weight_wen=1, full[wr_bank]=0, and the address is legal. The data is written to bank wr_bank at the decoded index and wcnt increments.
- The first accepted write of a bank (wcnt=0) latches waddr[30:23] into och_tag[wr_bank].
- Dropped write, full bank: weight_wen while full[wr_bank]=1 is dropped and sets err_ovf. wcnt is unchanged.
- Dropped write, bad address: a 3x3 write with pos > 8 is dropped, sets err_addr, and is not counted.
- Fill completion: on the accepted write with wcnt=159, in the next cycle full[wr_bank]=1, wr_bank toggles, wcnt=0, and fill_done=1 for exactly one cycle.
- Completion counts writes, not distinct addresses. Duplicate addresses overwrite and still count.
- Outputs: wr_bank_free = !full[wr_bank]; buf_ready = full[rd_bank]; rd_och = och_tag[rd_bank]. All are registered-state-derived, with no combinational path from the inputs.
- Read: rd_en with buf_ready=1 and a legal address gives rd_data = bank[rd_bank][index] and rd_vld=1 on the next cycle.
- Illegal read: rd_en with buf_ready=0 gives rd_vld=0 next cycle and sets err_rd. rd_en with a 3x3 pos > 8 gives rd_vld=0 and sets err_addr. rd_data holds its previous value in both cases.
- Release: mac_release with full[rd_bank]=1 clears full[rd_bank] and toggles rd_bank next cycle. mac_release with buf_ready=0 is ignored.
- A read issued in the same cycle as mac_release uses the pre-release bank.
- Simultaneous completion and release, different banks: both take effect in the same cycle.
- Simultaneous completion and release, same bank: not possible, because a bank cannot be both written and full.
- Write to a bank while MAC reads the other bank: no interaction.
- Sticky errors: once set, they stay set until err_clr. If err_clr and a new error occur in the same cycle, the flag ends set.
- Throughput: 1 write and 1 read per cycle, concurrently.

Test Plan:
- Reset, then 160 writes with och tag 0x05 and wdata=index: fill_done pulses one cycle after write 160; buf_ready=1, rd_och=0x05, wr_bank_free=1 (bank 1 empty).
- Read after fill: rd_k1=0, pos=8, word=15 -> rd_data=143 next cycle, rd_vld=1. rd_k1=1, word=3 -> rd_data=147.
- Fill bank 0 and bank 1 with no release: wr_bank_free=0. Write 321 is dropped and sets err_ovf. Then mac_release: buf_ready stays 1 with rd_och = bank 1 tag, and wr_bank_free=1.
- Fill bank 1 while reading bank 0 every cycle, with mac_release landing in the same cycle as write 160: next cycle full=2'b10, rd_bank=1, wr_bank=0, and read data before release is intact.
- rd_en with buf_ready=0 -> rd_vld=0 and err_rd=1. A 3x3 write with pos=9 -> err_addr=1 and wcnt unchanged. err_clr -> all flags 0.
- Assert rst_n low after 70 writes: all outputs 0 immediately, without waiting for a clock edge. After release, a full 160-write sequence completes normally.
